// File: rtl/alu_control_sequencer_pkg.sv
// Shared definitions for the ALU control sequencer: state encoding, opcode map,
// ALU function codes (also consumed by the ALU) and instruction-register field layout.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  localparam int OP_W  = 5;
  localparam int REG_W = 4;

  // IR field positions; each register field is REG_W bits wide below its MSB.
  localparam int IR_OP_MSB = 31;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RC_MSB = 18;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_ROR  = 4'd6;
  localparam logic [3:0] ALU_ROL  = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd15;

  // Non-ALU opcodes map to ALU_PASS, which doubles as the "not an ALU op" marker.
  function automatic logic [3:0] alu_decode(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      default: return ALU_PASS;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return alu_decode(op) != ALU_PASS;
  endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: IR feedback, memory
// ready, and every datapath strobe the sequencer owns.
interface alu_control_sequencer_if #(
  parameter int NREG = 16
);
  logic            start;
  logic [31:0]     ir;
  logic            mem_rdy;

  logic            PCout;
  logic            MARin;
  logic            IncPC;
  logic            Zin;
  logic            Zlowout;
  logic            PCin;
  logic            Read;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            Yin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic [3:0]      alu_op;
  logic            running;
  logic            illegal;

  modport master (
    input  start, ir, mem_rdy,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Rin, Rout, alu_op, running, illegal
  );

  modport slave (
    output start, ir, mem_rdy,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Rin, Rout, alu_op, running, illegal
  );
endinterface

// File: rtl/alu_control_sequencer_reg_select_decoder.sv
// Register-field to one-hot enable decoder; output is all-zero when disabled,
// so a single instance can never assert more than one register.
module reg_select_decoder #(
  parameter int NREG = 16,
  parameter int SELW = 4
) (
  input  logic            en,
  input  logic [SELW-1:0] sel,
  output logic [NREG-1:0] onehot
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  assign onehot = en ? (ONE << sel) : '0;

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired Moore sequencer for fetch (T0-T2) and three-operand register ALU
// execute (T3-T5); all strobes decode combinationally from state and IR.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic                    clk,
  input  logic                    clr,
  alu_control_sequencer_if.master bus
);

  state_t state;
  state_t state_next;

  logic [OPW-1:0]   op;
  logic [REG_W-1:0] ra;
  logic [REG_W-1:0] rb;
  logic [REG_W-1:0] rc;
  logic             alu_instr;
  logic             quiet_instr;
  logic             rin_en;
  logic             rout_en;
  logic [REG_W-1:0] rout_sel;
  logic             unused_ir;

  assign op  = bus.ir[IR_OP_MSB -: OPW];
  assign ra  = bus.ir[IR_RA_MSB -: REG_W];
  assign rb  = bus.ir[IR_RB_MSB -: REG_W];
  assign rc  = bus.ir[IR_RC_MSB -: REG_W];
  assign unused_ir = ^bus.ir[IR_RC_MSB-REG_W:0];

  assign alu_instr   = is_alu_op(op);
  assign quiet_instr = (op == OP_NOP) || (op == OP_HALT);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; clr acts asynchronously, forcing IDLE between edges.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_next;
  end

  // NOTE: every output is given a default before the case so no path through
  // this block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next  = state;
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.alu_op  = ALU_PASS;
    bus.running = 1'b1;
    bus.illegal = 1'b0;

    case (state)
      S_IDLE: begin
        // IDLE is the fully quiet reset state, so even alu_op reads zero here.
        bus.alu_op  = 4'd0;
        bus.running = 1'b0;
        if (bus.start) state_next = S_T0;
      end
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zin    = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        // Held through the memory stall; reloading PC from an unchanged Z is benign.
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (bus.mem_rdy) state_next = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        if (alu_instr) begin
          bus.Yin    = 1'b1;
          state_next = S_T4;
        end else if (op == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          bus.illegal = !quiet_instr;
          state_next  = S_T0;
        end
      end
      S_T4: begin
        bus.Zin    = 1'b1;
        bus.alu_op = alu_decode(op);
        state_next = S_T5;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        state_next  = S_T0;
      end
      S_HALT: begin
        bus.running = 1'b0;
      end
      default: begin
        bus.running = 1'b0;
        state_next  = S_IDLE;
      end
    endcase
  end

  // Rout reads rb while loading Y and rc while loading Z; Rin writes ra back from Z.
  assign rout_en  = ((state == S_T3) && alu_instr) || (state == S_T4);
  assign rout_sel = (state == S_T4) ? rc : rb;
  assign rin_en   = (state == S_T5);

  reg_select_decoder #(
    .NREG (NREG),
    .SELW (REG_W)
  ) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (bus.Rout)
  );

  reg_select_decoder #(
    .NREG (NREG),
    .SELW (REG_W)
  ) u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (bus.Rin)
  );

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired Moore control unit that drives the datapath control strobes for fetch plus the three-operand register ALU instructions.
- Fetch sequence is T0–T2; execute sequence is T3–T5.
- The instruction register value is read back from the datapath, and the unit emits one-hot register-file enables.
- It replaces hand-sequenced bench stimulus, and the datapath is driven solely by this block.

Parameters:
- NREG, 16, number of general registers (width of Rin/Rout).
- OPW, 5, opcode field width, IR[31:27].

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- ir  in  32  datapath IR contents; fields are op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15].
- mem_rdy  in  1  memory read data valid.
- PCout  out  1  PC to bus.
- MARin  out  1  MAR load.
- IncPC  out  1  ALU computes PC+1.
- Zin  out  1  Z register load.
- Zlowout  out  1  Z low word to bus.
- PCin  out  1  PC load.
- Read  out  1  memory read request.
- MDRin  out  1  MDR load.
- MDRout  out  1  MDR to bus.
- IRin  out  1  IR load.
- Yin  out  1  Y load.
- Rin  out  NREG  one-hot register write enable.
- Rout  out  NREG  one-hot register bus drive.
- alu_op  out  4  ALU function code, valid in T4 only.
- running  out  1  high in every state except IDLE and HALT.
- illegal  out  1  one-cycle pulse in T3 on an unsupported opcode.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. State is a register; all outputs decode combinationally from the state and ir.
- Reset:
  - On clr low, the state goes to IDLE immediately, regardless of clock.
  - All outputs are 0 while clr is low and in IDLE.
  - Reset mid-instruction abandons it with no partial strobes.
- State transitions:
  - IDLE -> T0 when start=1.
  - T0 -> T1.
  - T1 -> T2 only on a cycle with mem_rdy=1; otherwise stay in T1.
  - T2 -> T3.
  - T3 -> T4 for a supported ALU opcode.
  - T3 -> HALT for the halt opcode.
  - T3 -> T0 for nop or an illegal opcode.
  - T4 -> T5.
  - T5 -> T0.
  - HALT is absorbing until reset; start is ignored there.
- Strobes per state (every strobe is high for the full state duration and 0 in all other states):
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. All four are held through the stall; re-loading PC from an unchanged Z is harmless.
  - T2: MDRout, IRin.
  - T3: Rout[rb], Yin. For nop, halt and illegal opcodes, no strobes are driven in T3 except the illegal pulse.
  - T4: Rout[rc], Zin, alu_op=decode(op).
  - T5: Zlowout, Rin[ra].
- Latency: one instruction takes 6 cycles plus one cycle per mem_rdy-low cycle in T1. A nop/halt/illegal instruction takes 4 cycles.
- Opcodes and alu_op codes:

  | Instruction | Opcode | alu_op |
  |---|---|---|
  | add | 00011 | 0 |
  | sub | 00100 | 1 |
  | and | 00101 | 2 |
  | or | 00110 | 3 |
  | shr | 00111 | 4 |
  | shl | 01001 | 5 |
  | ror | 01010 | 6 |
  | rol | 01011 | 7 |
  | nop | 11010 | — |
  | halt | 11011 | — |

  - alu_op=15 (pass/idle) outside T4.
  - All other opcodes are illegal.
- Register fields: Rin/Rout are one-hot decodes of 4-bit fields. ra=rb or ra=rc is legal (Y/Z staging makes it safe).
- Invariants:
  - At most one bit of Rout is set in any cycle.
  - Zlowout and Rout are never high together.
  - Rin[0] is written like any other register (no hardwired zero).

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - the alu_op codes, shared with the ALU;
  - IR field bit positions.
- One sub-module, reg_select_decoder: field in, NREG one-hot out, with an enable. Two instances: Rin (ra, enabled in T5) and Rout (rb in T3, rc in T4, via a 2:1 mux of the field).

Test Plan:
1. Reset, then start=1, ir=32'h28918000 (and R1,R2,R3), mem_rdy=1.
   - Strobe sequence T0..T5 exactly as specified.
   - Rout=16'h0004 in T3, Rout=16'h0008 in T4 with alu_op=2, Rin=16'h0002 in T5.
   - Next cycle is T0.
2. ir=32'h48918000 (shl R1,R2,R3), mem_rdy low for 3 cycles in T1.
   - T1 lasts 4 cycles with Read/MDRin/PCin/Zlowout held high.
   - alu_op=5 in T4; instruction total is 9 cycles.
3. ir=32'hD8000000 (halt).
   - After T3 the state is HALT and running=0.
   - start pulses are ignored; Rin and Rout stay 0.
4. ir=32'hF8000000 (illegal).
   - illegal pulses exactly one cycle in T3; no Yin/Rout in T3.
   - Returns to T0 and fetches the next instruction normally.
5. clr driven low asynchronously mid-T4 (between clock edges).
   - All outputs drop to 0 immediately and the state is IDLE.
   - After release, nothing happens until start.
6. ir=32'h19108000 (add R2,R2,R1).
   - Rout=16'h0004 in T3, Rout=16'h0002 in T4, Rin=16'h0004 in T5, alu_op=0.
   - Invariant checks hold throughout.
